// File: rtl/ps2_pkg.sv
// Shared PS/2 byte constants and decode-state enum for the key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  // Keyboard status/response bytes that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_byte_sink.sv
// Pops bytes from the PS/2 controller FIFO; byte_valid marks the accepting edge.
module ps2_byte_sink (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_data,
  output logic       nextdata_n,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  // The pop strobe being low blocks the next cycle, so a byte is never taken twice.
  assign byte_valid = ps2_ready & nextdata_n;
  assign rx_byte    = ps2_data;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) nextdata_n <= 1'b1;
    else       nextdata_n <= ~byte_valid;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 make/break/E0/E1 sequences into held-key, press counter and overflow flag.
// Optional prefix idle timeout: define PS2_KT_TIMEOUT_EN.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int COUNT_W     = 8,
  parameter int PAUSE_LEN   = 7,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [7:0]         ps2_data,
  input  logic               ps2_ready,
  input  logic               ps2_overflow,
  output logic               nextdata_n,
  input  logic               ovf_clr,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_held,
  output logic               key_event,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_sticky
);

  localparam int PW = $clog2(PAUSE_LEN + 1);

  if (COUNT_W < 4 || (COUNT_W % 4) != 0 || TIMEOUT_CYC < 2 || PAUSE_LEN < 1) begin : g_param_chk
    $error("ps2_key_tracker: illegal parameter value");
  end

  logic          byte_valid;
  logic [7:0]    rx_byte;
  state_t        state;
  logic [PW-1:0] pause_cnt;
  logic          mk, bk, ev_ext, same_key, tmo;

  ps2_byte_sink u_sink (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_ready  (ps2_ready),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  always_comb begin
    mk     = 1'b0;
    bk     = 1'b0;
    ev_ext = 1'b0;
    if (byte_valid) begin
      case (state)
        S_IDLE:    mk = !(rx_byte inside {PS2_EXT, PS2_BRK, PS2_PAUSE}) && !is_status(rx_byte);
        S_EXT:     begin mk = (rx_byte != PS2_BRK) && (rx_byte != PS2_EXT); ev_ext = 1'b1; end
        S_BRK:     bk = (rx_byte != PS2_BRK) && (rx_byte != PS2_EXT);
        S_EXT_BRK: begin bk = 1'b1; ev_ext = 1'b1; end
        default:   ;
      endcase
    end
  end

  assign same_key = ({key_ext, key_code} == {ev_ext, rx_byte});

`ifdef PS2_KT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] idle_cnt;

  assign tmo = (state != S_IDLE) && !byte_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                                idle_cnt <= '0;
    else if (byte_valid || tmo || state == S_IDLE) idle_cnt <= '0;
    else                                      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= S_IDLE;
      pause_cnt   <= '0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_held    <= 1'b0;
      key_event   <= 1'b0;
      press_count <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (ps2_overflow) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;

      // A repeat of the held key is typematic and must not count as a new press.
      if (mk && !(key_held && same_key)) begin
        key_code    <= rx_byte;
        key_ext     <= ev_ext;
        key_held    <= 1'b1;
        key_event   <= 1'b1;
        press_count <= press_count + 1'b1;
      end
      if (bk && same_key) key_held <= 1'b0;

      if (byte_valid) begin
        case (state)
          S_IDLE:
            if (rx_byte == PS2_EXT)        state <= S_EXT;
            else if (rx_byte == PS2_BRK)   state <= S_BRK;
            else if (rx_byte == PS2_PAUSE) begin
              state     <= S_PAUSE;
              pause_cnt <= PW'(PAUSE_LEN);
            end
          S_EXT:
            if (rx_byte == PS2_BRK)        state <= S_EXT_BRK;
            else if (rx_byte != PS2_EXT)   state <= S_IDLE;
          S_BRK:
            if (rx_byte == PS2_EXT)        state <= S_EXT;
            else if (rx_byte != PS2_BRK)   state <= S_IDLE;
          S_EXT_BRK:                       state <= S_IDLE;
          S_PAUSE: begin
            pause_cnt <= pause_cnt - 1'b1;
            if (pause_cnt == PW'(1))       state <= S_IDLE;
          end
          default:                         state <= S_IDLE;
        endcase
      end else if (tmo) begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a prefix-flag reference model and per-cycle compare.
module tb_ps2_key_tracker;

  localparam int CW = 8;
  localparam int TO = 50;

  logic          clk = 1'b0, clrn = 1'b0;
  logic [7:0]    ps2_data = 8'h00;
  logic          ps2_ready = 1'b0, ps2_overflow = 1'b0, ovf_clr = 1'b0;
  logic          nextdata_n, key_ext, key_held, key_event, ovf_sticky;
  logic [7:0]    key_code;
  logic [CW-1:0] press_count;

  ps2_key_tracker #(.COUNT_W(CW), .PAUSE_LEN(7), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .nextdata_n(nextdata_n), .ovf_clr(ovf_clr),
    .key_code(key_code), .key_ext(key_ext), .key_held(key_held), .key_event(key_event),
    .press_count(press_count), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  // Reference model: pending-prefix flags plus the visible key state.
  bit            m_nd, m_acc, m_ext, m_held, m_ev, m_ovf, p_ext, p_brk;
  logic [7:0]    m_code;
  logic [CW-1:0] m_cnt;
  int            p_pause, idle;
  int            checks = 0, errors = 0, ev_seen = 0;

  function automatic void m_make(input logic [7:0] c, input bit e);
    if (!(m_held && m_code == c && m_ext == e)) begin
      m_code = c; m_ext = e; m_held = 1; m_ev = 1; m_cnt = m_cnt + 1'b1;
    end
  endfunction

  function automatic void m_break(input logic [7:0] c, input bit e);
    if (m_code == c && m_ext == e) m_held = 0;
  endfunction

  function automatic void m_decode(input logic [7:0] b);
    if (p_pause > 0) p_pause--;
    else if (p_ext && p_brk) begin m_break(b, 1); p_ext = 0; p_brk = 0; end
    else if (p_brk) begin
      if (b == 8'hE0) begin p_brk = 0; p_ext = 1; end
      else if (b != 8'hF0) begin m_break(b, 0); p_brk = 0; end
    end else if (p_ext) begin
      if (b == 8'hF0) p_brk = 1;
      else if (b != 8'hE0) begin m_make(b, 1); p_ext = 0; end
    end else begin
      case (b)
        8'hE0: p_ext = 1;
        8'hF0: p_brk = 1;
        8'hE1: p_pause = 7;
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
        default: m_make(b, 0);
      endcase
    end
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_nd = 1; m_code = 0; m_ext = 0; m_held = 0; m_ev = 0; m_cnt = 0; m_ovf = 0;
      p_ext = 0; p_brk = 0; p_pause = 0; idle = 0;
    end else begin
      m_acc = ps2_ready && m_nd;
      m_nd  = !m_acc;
      m_ev  = 0;
      if (ps2_overflow) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (m_acc) begin
        idle = 0;
        m_decode(ps2_data);
      end else if (p_ext || p_brk || p_pause > 0) begin
`ifdef PS2_KT_TIMEOUT_EN
        idle++;
        if (idle == TO) begin p_ext = 0; p_brk = 0; p_pause = 0; idle = 0; end
`endif
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({nextdata_n, key_code, key_ext, key_held, key_event, press_count, ovf_sticky} !==
        {m_nd, m_code, m_ext, m_held, m_ev, m_cnt, m_ovf}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got nd=%b code=%h ext=%b held=%b ev=%b cnt=%0d ovf=%b exp nd=%b code=%h ext=%b held=%b ev=%b cnt=%0d ovf=%b",
               $time, nextdata_n, key_code, key_ext, key_held, key_event, press_count, ovf_sticky,
               m_nd, m_code, m_ext, m_held, m_ev, m_cnt, m_ovf);
    end
    if (key_event === 1'b1) ev_seen++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); ps2_data = b; ps2_ready = 1'b1;
    @(negedge clk); ps2_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 clrn = 1'b0; ps2_ready = 1'b0;
    @(negedge clk); #2 clrn = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ev0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_nd", 32'(nextdata_n), 1);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_cnt", 32'(press_count), 0);
    #2 clrn = 1'b1;

    // Make/break plus handshake: ready held two cycles must pop only once.
    ev0 = ev_seen;
    @(negedge clk); ps2_data = 8'h1C; ps2_ready = 1'b1;
    @(negedge clk); chk("nd_low", 32'(nextdata_n), 0);
    @(negedge clk); chk("nd_high", 32'(nextdata_n), 1); ps2_ready = 1'b0;
    send(8'hF0); send(8'h1C); idle_cycles(3);
    chk("t1_code", 32'(key_code), 32'h1C);
    chk("t1_ext", 32'(key_ext), 0);
    chk("t1_held", 32'(key_held), 0);
    chk("t1_cnt", 32'(press_count), 1);
    chk("t1_events", 32'(ev_seen - ev0), 1);

    // Typematic repeats
    do_reset(); ev0 = ev_seen;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle_cycles(2);
    chk("t2_cnt", 32'(press_count), 1);
    chk("t2_events", 32'(ev_seen - ev0), 1);

    // Extended key; a plain break of the same code must not release it
    do_reset();
    send(8'hE0); send(8'h75); idle_cycles(1);
    chk("t3_held1", 32'(key_held), 1);
    chk("t3_ext", 32'(key_ext), 1);
    send(8'hF0); send(8'h75); idle_cycles(1);
    chk("t3_plain_brk", 32'(key_held), 1);
    send(8'hE0); send(8'hF0); send(8'h75); idle_cycles(1);
    chk("t3_held0", 32'(key_held), 0);
    chk("t3_code", 32'(key_code), 32'h75);
    chk("t3_cnt", 32'(press_count), 1);

    // Status byte, pause sequence swallowed
    do_reset(); ev0 = ev_seen;
    send(8'hFA);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1B); idle_cycles(1);
    chk("t4_cnt", 32'(press_count), 1);
    chk("t4_code", 32'(key_code), 32'h1B);
    chk("t4_events", 32'(ev_seen - ev0), 1);

    // Counter wrap and overflow flag
    do_reset();
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h1B);
    idle_cycles(1);
    chk("t5_wrap", 32'(press_count), 0);
    chk("t5_code", 32'(key_code), 32'h1B);
    @(negedge clk); ps2_overflow = 1'b1;
    @(negedge clk); ps2_overflow = 1'b0;
    chk("t5_ovf_set", 32'(ovf_sticky), 1);
    ps2_overflow = 1'b1; ovf_clr = 1'b1;
    @(negedge clk); ps2_overflow = 1'b0;
    chk("t5_set_wins", 32'(ovf_sticky), 1);
    @(negedge clk); ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(ovf_sticky), 0);

    // Prefix left pending for 60 cycles
    do_reset();
    send(8'hE0); idle_cycles(60); send(8'h1C); idle_cycles(1);
`ifdef PS2_KT_TIMEOUT_EN
    chk("t6_timeout_ext", 32'(key_ext), 0);
`else
    chk("t6_persist_ext", 32'(key_ext), 1);
`endif
    chk("t6_code", 32'(key_code), 32'h1C);

    // Reset in the middle of an E0 sequence
    send(8'hE0);
    @(negedge clk); #2 clrn = 1'b0;
    @(negedge clk);
    chk("t7_rst_held", 32'(key_held), 0);
    chk("t7_rst_code", 32'(key_code), 0);
    chk("t7_rst_cnt", 32'(press_count), 0);
    #2 clrn = 1'b1;
    send(8'h75); idle_cycles(1);
    chk("t7_ext", 32'(key_ext), 0);
    chk("t7_code", 32'(key_code), 32'h75);
    chk("t7_cnt", 32'(press_count), 1);

    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Consumes the byte stream from PS2_keyboard_controller via its ready/nextdata_n handshake and decodes make, break, E0-extended and E1-pause sequences.
- Maintains the currently held key, a wrap-around press counter and a sticky overflow flag.
- Presents these as registered outputs for the hex/ASCII/7-seg display chain.
- Parametrised successor of the board display front-end: posedge-only logic, real break/extended decoding, typematic-repeat suppression.

Parameters:
- COUNT_W, 8, press counter width; must be a multiple of 4 and at least 4.
- PAUSE_LEN, 7, bytes following an E1 prefix that are swallowed.
- TIMEOUT_CYC, 1000000, idle cycles before a pending prefix is abandoned; used only with PS2_KT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clrn  in  1  asynchronous active-low reset.
- ps2_data  in  8  byte from controller FIFO head.
- ps2_ready  in  1  FIFO non-empty.
- ps2_overflow  in  1  controller FIFO overflow.
- nextdata_n  out  1  active-low pop strobe to controller.
- ovf_clr  in  1  clears ovf_sticky.
- key_code  out  8  last make code (prefix stripped).
- key_ext  out  1  last make was E0-extended.
- key_held  out  1  key_code is currently pressed.
- key_event  out  1  one-cycle pulse on a counted new press.
- press_count  out  COUNT_W  number of counted presses, modulo 2^COUNT_W.
- ovf_sticky  out  1  overflow seen since reset or last clear.

Behaviour:
- Reset (clrn=0, asynchronous): nextdata_n=1, key_code=0, key_ext=0, key_held=0, key_event=0, press_count=0, ovf_sticky=0, FSM=IDLE, pause counter=0. Asserting reset mid-sequence discards any partial sequence.
- Handshake:
  - A byte is accepted on a posedge where ps2_ready=1 and nextdata_n=1.
  - On acceptance, nextdata_n is registered low for exactly one cycle, then returns high.
  - Maximum throughput is one byte per 2 cycles; a byte is never accepted twice.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- Transitions on each accepted byte b:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE (counter=PAUSE_LEN); AA/FA/EE/FE/00/FF ignored; otherwise a make with ext=0.
  - EXT: F0->EXT_BRK; E0 stays EXT; otherwise a make with ext=1, then IDLE.
  - BRK: F0 stays BRK; E0->EXT (malformed, restart); otherwise a break with ext=0, then IDLE.
  - EXT_BRK: otherwise a break with ext=1, then IDLE.
  - PAUSE: decrement the counter; at 0 return to IDLE. No key outputs change.
- Make (code c, ext e):
  - If key_held=1 and {key_ext,key_code}=={e,c}, it is a typematic repeat: no output change.
  - Otherwise: key_code<=c, key_ext<=e, key_held<=1, press_count<=press_count+1 (wraps), key_event=1 for the next cycle.
- Break:
  - If {e,c} matches {key_ext,key_code}, key_held<=0; key_code and key_ext are retained.
  - Otherwise the break is ignored.
- Latency: outputs update on the posedge that accepts the final byte; visible the following cycle.
- Overflow:
  - ovf_sticky<=1 on any cycle with ps2_overflow=1.
  - ovf_clr=1 clears it; if both occur in the same cycle, set wins.
- press_count wraps from 2^COUNT_W-1 to 0 with no flag.

Optional Feature:
- Macro PS2_KT_TIMEOUT_EN.
- Defined:
  - An idle counter runs in states EXT, BRK, EXT_BRK and PAUSE; it reloads on every accepted byte.
  - After TIMEOUT_CYC cycles with no accepted byte, the FSM forces IDLE with no output change.
  - A byte accepted in the expiry cycle takes priority and is decoded normally.
- Undefined: no counter; prefix states persist indefinitely.

Decomposition:
- Package ps2_pkg holds:
  - byte constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, plus status bytes AA/FA/EE/FE/00/FF;
  - the FSM state enum.
- Sub-module ps2_byte_sink:
  - owns the ready/nextdata_n handshake;
  - emits byte_valid pulse plus byte;
  - the decode FSM lives in ps2_key_tracker.

Test Plan:
- Reset then 1C,F0,1C -> key_code=1C, key_ext=0, one key_event, press_count=1, key_held=0 after break, nextdata_n low one cycle per byte.
- 1C,1C,1C,F0,1C (typematic) -> press_count=1, exactly one key_event.
- E0,75,E0,F0,75 -> key_code=75, key_ext=1, count=1, key_held 1 then 0; plain F0,75 during hold leaves key_held=1.
- E1,14,77,E1,F0,14,F0,77 then 1B -> pause swallowed, only 1B counted, count=1, key_code=1B.
- 256 distinct alternating makes (1C/1B) with COUNT_W=8 -> press_count wraps to 0; ps2_overflow pulse -> ovf_sticky=1; simultaneous ovf_clr keeps 1; ovf_clr alone -> 0.
- With PS2_KT_TIMEOUT_EN and TIMEOUT_CYC=50: E0, wait 60 cycles, 1C -> key_ext=0; reset asserted between E0 and 75 -> all outputs return to reset values.
